// File: rtl/ring_dwell_sequencer.sv
//==============================================================================
// ring_dwell_sequencer -- pops ring selector entries and holds each for a dwell
// Rev 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module ring_dwell_sequencer #(
    parameter int DATA_W  = 4,
    parameter int IDX_W   = 7,
    parameter int CNT_W   = 8,
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [DWELL_W-1:0] dwell_len,
    input  logic [DATA_W-1:0]  ring_dout,
    input  logic [IDX_W-1:0]   ring_index,
    input  logic [CNT_W-1:0]   ring_count,
    input  logic               ring_ready,
    output logic               ring_rd_en,
    output logic [DATA_W-1:0]  sel_out,
    output logic [IDX_W-1:0]   sel_index,
    output logic               sel_valid,
    output logic               sel_stall,
    output logic               sweep_start,
    output logic               sweep_done,
    output logic [DWELL_W-1:0] sweep_cnt,
    output logic               busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DWELL = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [DWELL_W-1:0] dwell_ctr_q, dwell_ctr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  sel_out_q, sel_out_d;
    logic [IDX_W-1:0]   sel_index_q, sel_index_d;
    logic               sel_valid_q, sel_valid_d;
    logic               sweep_start_q, sweep_start_d;
    logic [DWELL_W-1:0] sweep_cnt_q, sweep_cnt_d;

    logic               w_expired;
    logic               w_reload;
    logic               w_take;
    logic               w_done;
    logic [IDX_W-1:0]   w_last_idx;
    logic [DWELL_W-1:0] w_dwell_load;

    assign w_expired    = (state_q == ST_DWELL) && (dwell_ctr_q == '0);
    assign w_reload     = (state_q != ST_IDLE) && (ring_count != cnt_q);
    assign w_last_idx   = IDX_W'(cnt_q) - IDX_W'(1);
    assign w_dwell_load = (dwell_len == '0) ? '0 : dwell_len - DWELL_W'(1);

    // A reload pre-empts both the pop and the sweep boundary of an expiring dwell.
    assign w_take = ring_ready && enable && (ring_count != '0) && !w_reload &&
                    ((state_q == ST_IDLE) || w_expired || (state_q == ST_WAIT));
    assign w_done = w_expired && !w_reload && (sel_index_q == w_last_idx);

    always_comb begin
        state_d       = state_q;
        dwell_ctr_d   = dwell_ctr_q;
        cnt_d         = cnt_q;
        sel_out_d     = sel_out_q;
        sel_index_d   = sel_index_q;
        sel_valid_d   = sel_valid_q;
        sweep_start_d = 1'b0;
        sweep_cnt_d   = sweep_cnt_q;

        if (w_done) begin
            sweep_cnt_d = sweep_cnt_q + DWELL_W'(1);
        end

        if (w_reload) begin
            state_d     = ST_IDLE;
            sel_valid_d = 1'b0;
        end else if (w_take) begin
            state_d       = ST_DWELL;
            sel_out_d     = ring_dout;
            sel_index_d   = ring_index;
            sel_valid_d   = 1'b1;
            dwell_ctr_d   = w_dwell_load;
            cnt_d         = ring_count;
            sweep_start_d = (ring_index == '0);
        end else begin
            case (state_q)
                ST_DWELL: begin
                    if (dwell_ctr_q != '0) begin
                        dwell_ctr_d = dwell_ctr_q - DWELL_W'(1);
                    end else if (enable) begin
                        state_d = ST_WAIT;
                    end else begin
                        state_d     = ST_IDLE;
                        sel_valid_d = 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (!enable) begin
                        state_d     = ST_IDLE;
                        sel_valid_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            dwell_ctr_q   <= '0;
            cnt_q         <= '0;
            sel_out_q     <= '0;
            sel_index_q   <= '0;
            sel_valid_q   <= 1'b0;
            sweep_start_q <= 1'b0;
            sweep_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            dwell_ctr_q   <= dwell_ctr_d;
            cnt_q         <= cnt_d;
            sel_out_q     <= sel_out_d;
            sel_index_q   <= sel_index_d;
            sel_valid_q   <= sel_valid_d;
            sweep_start_q <= sweep_start_d;
            sweep_cnt_q   <= sweep_cnt_d;
        end
    end

    // The pop strobe is combinational, so it is masked while reset is held low.
    assign ring_rd_en  = w_take && rst;
    assign sel_out     = sel_out_q;
    assign sel_index   = sel_index_q;
    assign sel_valid   = sel_valid_q;
    assign sel_stall   = (state_q == ST_WAIT);
    assign sweep_start = sweep_start_q;
    assign sweep_done  = w_done;
    assign sweep_cnt   = sweep_cnt_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_ring_dwell_sequencer.sv
//==============================================================================
// tb_ring_dwell_sequencer -- scoreboard bench with a behavioural ring front end
// Rev 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ring_dwell_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [15:0] dwell_len;
    logic [3:0]  ring_dout;
    logic [6:0]  ring_index;
    logic [7:0]  ring_count;
    logic        ring_ready;
    logic        ring_rd_en;
    logic [3:0]  sel_out;
    logic [6:0]  sel_index;
    logic        sel_valid;
    logic        sel_stall;
    logic        sweep_start;
    logic        sweep_done;
    logic [15:0] sweep_cnt;
    logic        busy;

    ring_dwell_sequencer #(
        .DATA_W(4), .IDX_W(7), .CNT_W(8), .DWELL_W(16)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .dwell_len(dwell_len),
        .ring_dout(ring_dout), .ring_index(ring_index), .ring_count(ring_count),
        .ring_ready(ring_ready), .ring_rd_en(ring_rd_en), .sel_out(sel_out),
        .sel_index(sel_index), .sel_valid(sel_valid), .sel_stall(sel_stall),
        .sweep_start(sweep_start), .sweep_done(sweep_done), .sweep_cnt(sweep_cnt),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  sel;
        logic [6:0]  idx;
        logic        start;
        logic [15:0] cnt;
        int          gap;
    } exp_t;

    exp_t       exp_q[$];
    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    int         done_total = 0;
    int         done_last = -1;
    int         stall_total = 0;
    int         pop_total = 0;
    logic [3:0] mem [0:15];
    int         ptr = 0;
    bit         popped;
    bit         stim_done = 0;

    function automatic void push(input int s, input int i, input bit st, input int c, input int g);
        exp_t e;
        e.sel = 4'(s); e.idx = 7'(i); e.start = st; e.cnt = 16'(c); e.gap = g;
        exp_q.push_back(e);
    endfunction

    task automatic chk(input string name, input longint act, input longint expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic drive_ring();
        ring_dout  = mem[ptr];
        ring_index = 7'(ptr);
    endtask

    // Inputs change 1 ns after the edge; the pop decision is sampled 3 ns after it.
    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            #2;
            popped = ring_rd_en;
            @(posedge clk);
            #1;
            if (popped) ptr = (ptr + 1 >= int'(ring_count)) ? 0 : ptr + 1;
            drive_ring();
            cyc++;
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_sel_out"},     sel_out,     0);
        chk({tag, "_sel_index"},   sel_index,   0);
        chk({tag, "_sel_valid"},   sel_valid,   0);
        chk({tag, "_sel_stall"},   sel_stall,   0);
        chk({tag, "_sweep_start"}, sweep_start, 0);
        chk({tag, "_sweep_done"},  sweep_done,  0);
        chk({tag, "_sweep_cnt"},   sweep_cnt,   0);
        chk({tag, "_busy"},        busy,        0);
        chk({tag, "_ring_rd_en"},  ring_rd_en,  0);
    endtask

    initial begin
        rst = 1'b0; enable = 1'b0; dwell_len = 16'd4; ring_ready = 1'b0; ring_count = 8'd3;
        mem[0] = 4'd5; mem[1] = 4'd9; mem[2] = 4'd2; mem[3] = 4'd7;
        for (int k = 4; k < 16; k++) mem[k] = 4'd0;
        ptr = 0;
        drive_ring();
        fork
            begin : stimulus
                repeat (2) @(posedge clk);
                #1;
                check_zero("reset");
                @(posedge clk);
                #1;
                rst = 1'b1; cyc = 0;
                enable = 1'b1; ring_ready = 1'b1;

                // ring {5,9,2}, dwell 4: pops at cycles 0,4,8,12
                push(5,0,1,0,-1); push(9,1,0,0,4); push(2,2,0,0,4); push(5,0,1,1,4);
                step(16);
                chk("done_count_dwell4", done_total, 1);
                chk("done_cycle_dwell4", done_last, 12);

                // dwell 0: one pop every cycle, sweep_done every third cycle
                dwell_len = 16'd0;
                push(9,1,0,1,4); push(2,2,0,1,1); push(5,0,1,2,1);
                push(9,1,0,2,1); push(2,2,0,2,1); push(5,0,1,3,1);
                step(6);
                chk("done_count_dwell0", done_total, 3);
                chk("done_cycle_dwell0", done_last, 21);
                chk("pops_dwell0", pop_total, 10);

                dwell_len = 16'd1;
                push(9,1,0,3,1); push(2,2,0,3,1); push(5,0,1,4,1);
                step(3);
                chk("done_count_dwell1", done_total, 4);
                chk("done_cycle_dwell1", done_last, 24);

                // ring not ready for 3 cycles at the expiry in cycle 29
                dwell_len = 16'd4;
                push(9,1,0,4,1);
                step(4);
                ring_ready = 1'b0;
                step(3);
                chk("stall_flag", sel_stall, 1);
                chk("stall_sel_held", sel_out, 9);
                chk("stall_valid_held", sel_valid, 1);
                chk("stall_no_pop", pop_total, 14);
                ring_ready = 1'b1;
                push(2,2,0,4,7);
                step(4);
                chk("stall_cycles", stall_total, 3);

                // enable dropped two cycles into a 6-cycle dwell
                dwell_len = 16'd6;
                push(5,0,1,5,4);
                step(3);
                enable = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    chk("disable_valid_held", sel_valid, 1);
                    step(1);
                end
                chk("disable_valid_off", sel_valid, 0);
                chk("disable_busy_off", busy, 0);
                chk("disable_sel_held", sel_out, 5);
                chk("disable_done_count", done_total, 5);
                step(3);
                chk("disable_no_pop", pop_total, 16);

                // ring grows 3 -> 4 in the middle of a dwell
                enable = 1'b1; dwell_len = 16'd4;
                push(9,1,0,5,10);
                step(2);
                ring_count = 8'd4; ring_ready = 1'b0;
                step(1);
                chk("reload_valid_off", sel_valid, 0);
                chk("reload_busy_off", busy, 0);
                chk("reload_sweep_cnt", sweep_cnt, 5);
                chk("reload_no_done", done_total, 5);
                ptr = 0; drive_ring(); ring_ready = 1'b1;
                push(5,0,1,5,3); push(9,1,0,5,4); push(2,2,0,5,4); push(7,3,0,5,4); push(5,0,1,6,4);
                step(17);
                chk("reload_done_count", done_total, 6);
                chk("reload_done_cycle", done_last, 65);

                // asynchronous reset in the middle of a dwell
                step(1);
                chk("queue_drained", exp_q.size(), 0);
                #1 rst = 1'b0;
                #1 check_zero("async_reset");
                @(posedge clk);
                #1;
                rst = 1'b1; cyc++;
                ptr = 0; drive_ring();
                push(5,0,1,0,-1); push(9,1,0,0,4);
                step(6);
                for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(posedge clk);
                chk("final_queue_empty", exp_q.size(), 0);
                stim_done = 1'b1;
            end
            begin : monitor
                exp_t e;
                int   g;
                int   last_evt;
                bit   rd_prev;
                last_evt = -1;
                rd_prev  = 1'b0;
                forever begin
                    @(negedge clk);
                    if (!rst) begin
                        rd_prev  = 1'b0;
                        last_evt = -1;
                    end else begin
                        if (sweep_done) begin done_total++; done_last = cyc; end
                        if (sel_stall) stall_total++;
                        if (ring_rd_en) pop_total++;
                        if (rd_prev) begin
                            g = (last_evt < 0) ? -1 : cyc - last_evt;
                            tests++;
                            if (exp_q.size() == 0) begin
                                fails++;
                                $display("FAIL unexpected_output: got sel=%0d idx=%0d at cycle %0d, none expected",
                                         sel_out, sel_index, cyc);
                            end else begin
                                e = exp_q.pop_front();
                                if (sel_out !== e.sel || sel_index !== e.idx || sel_valid !== 1'b1 ||
                                    sweep_start !== e.start || sweep_cnt !== e.cnt ||
                                    (e.gap >= 0 && g != e.gap)) begin
                                    fails++;
                                    $display("FAIL output_event: got sel=%0d idx=%0d valid=%0b start=%0b cnt=%0d gap=%0d expected sel=%0d idx=%0d valid=1 start=%0b cnt=%0d gap=%0d",
                                             sel_out, sel_index, sel_valid, sweep_start, sweep_cnt, g,
                                             e.sel, e.idx, e.start, e.cnt, e.gap);
                                end
                            end
                            last_evt = cyc;
                        end
                        rd_prev = ring_rd_en;
                    end
                end
            end
        join_any
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
